// File: rtl/risk_pkg.sv
// Shared encodings and default widths for the RISK core command path.
package risk_pkg;

   localparam int ADDR_W   = 15;
   localparam int STRIDE_W = 14;
   localparam int REG_W    = 5;

   // Function codes understood by the RISK core.
   typedef enum logic [2:0] {
      RISK_LOAD  = 3'b000,
      RISK_STORE = 3'b001,
      RISK_ZERO  = 3'b010,
      RISK_NOP   = 3'b111
   } risk_func_e;

   // Tile command opcodes from the instruction decoder.
   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ZERO  = 2'b10,
      OP_RSVD  = 2'b11
   } cmd_op_e;

   // Sequencer control states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SLOT   = 2'b01,
      ST_FINISH = 2'b10
   } seq_state_e;

endpackage

// File: rtl/risk_addr_walker.sv
// Walks a tile grid in row-major order, producing the current tile's
// address and register index from running accumulators (no multipliers).
module risk_addr_walker #(
   parameter int ADDR_W = 15,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] step_x,
   input  logic [ADDR_W-1:0] step_y,
   input  logic [3:0]        tiles_x,
   input  logic [3:0]        tiles_y,
   input  logic [REG_W-1:0]  reg_base,
   output logic [ADDR_W-1:0] addr,
   output logic [REG_W-1:0]  reg_idx,
   output logic              last
);

   logic [3:0]        tx_q, tx_d, ty_q, ty_d;
   logic [3:0]        tiles_x_q, tiles_x_d, tiles_y_q, tiles_y_d;
   logic [ADDR_W-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
   logic [ADDR_W-1:0] row_addr_q, row_addr_d, addr_q, addr_d;
   logic [REG_W-1:0]  reg_q, reg_d;

   // Next tile position: restart on load, step tx (or wrap into the next row) on advance.
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      tx_d       = tx_q;
      ty_d       = ty_q;
      tiles_x_d  = tiles_x_q;
      tiles_y_d  = tiles_y_q;
      step_x_d   = step_x_q;
      step_y_d   = step_y_q;
      row_addr_d = row_addr_q;
      addr_d     = addr_q;
      reg_d      = reg_q;
      if (load) begin
         tx_d       = '0;
         ty_d       = '0;
         tiles_x_d  = tiles_x;
         tiles_y_d  = tiles_y;
         step_x_d   = step_x;
         step_y_d   = step_y;
         row_addr_d = base_addr;
         addr_d     = base_addr;
         reg_d      = reg_base;
      end else if (advance) begin
         // Linear tile index grows by one per tile, so the reg index just increments.
         reg_d = reg_q + 1'b1;
         if (tx_q == tiles_x_q) begin
            tx_d       = '0;
            ty_d       = ty_q + 1'b1;
            row_addr_d = row_addr_q + step_y_q;
            addr_d     = row_addr_q + step_y_q;
         end else begin
            tx_d   = tx_q + 1'b1;
            addr_d = addr_q + step_x_q;
         end
      end
   end

   // Walker state registers.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous: it is only looked at on the clock edge, like any data input.
      if (reset) begin
         tx_q       <= '0;
         ty_q       <= '0;
         tiles_x_q  <= '0;
         tiles_y_q  <= '0;
         step_x_q   <= '0;
         step_y_q   <= '0;
         row_addr_q <= '0;
         addr_q     <= '0;
         reg_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         tiles_x_q  <= tiles_x_d;
         tiles_y_q  <= tiles_y_d;
         step_x_q   <= step_x_d;
         step_y_q   <= step_y_d;
         row_addr_q <= row_addr_d;
         addr_q     <= addr_d;
         reg_q      <= reg_d;
      end
   end

   assign addr    = addr_q;
   assign reg_idx = reg_q;
   assign last    = (tx_q == tiles_x_q) && (ty_q == tiles_y_q);

endmodule

// File: rtl/risk_tile_sequencer.sv
// Expands one tile command into a timed stream of per-tile RISK core
// operations, holding each tile's address for a full memory-latency slot.
module risk_tile_sequencer #(
   parameter int MEM_LAT  = 4,
   parameter int ADDR_W   = 15,
   parameter int STRIDE_W = 14,
   parameter int REG_W    = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [REG_W-1:0]    cmd_reg_base,
   input  logic [ADDR_W-1:0]   cmd_base_addr,
   input  logic [STRIDE_W-1:0] cmd_stride_x,
   input  logic [STRIDE_W-1:0] cmd_stride_y,
   input  logic [ADDR_W-1:0]   cmd_step_x,
   input  logic [ADDR_W-1:0]   cmd_step_y,
   input  logic [3:0]          cmd_tiles_x,
   input  logic [3:0]          cmd_tiles_y,
   output logic [2:0]          risk_func,
   output logic [REG_W-1:0]    risk_reg,
   output logic [ADDR_W-1:0]   risk_addr,
   output logic [STRIDE_W-1:0] risk_stride_x,
   output logic [STRIDE_W-1:0] risk_stride_y,
   output logic                busy,
   output logic                done
);

   import risk_pkg::*;

   localparam int SLOT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST_LONG = SLOT_W'(MEM_LAT);

   seq_state_e          state_q, state_d;
   cmd_op_e             op_q, op_d;
   risk_func_e          func_q, func_d;
   logic [SLOT_W-1:0]   slot_q, slot_d, slot_last;
   logic [STRIDE_W-1:0] stride_x_q, stride_x_d, stride_y_q, stride_y_d;
   logic                busy_q, busy_d, ready_q, ready_d, done_q, done_d;
   logic                walk_load, walk_adv, walk_last;

   risk_addr_walker #(.ADDR_W(ADDR_W), .REG_W(REG_W)) u_walker (
      .clk       (clk),
      .reset     (reset),
      .load      (walk_load),
      .advance   (walk_adv),
      .base_addr (cmd_base_addr),
      .step_x    (cmd_step_x),
      .step_y    (cmd_step_y),
      .tiles_x   (cmd_tiles_x),
      .tiles_y   (cmd_tiles_y),
      .reg_base  (cmd_reg_base),
      .addr      (risk_addr),
      .reg_idx   (risk_reg),
      .last      (walk_last)
   );

   // Next state, command latch, and next-cycle output values (outputs are registered).
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      slot_d     = slot_q;
      stride_x_d = stride_x_q;
      stride_y_d = stride_y_q;
      walk_load  = 1'b0;
      walk_adv   = 1'b0;
      // Load and store hold the address for the memory latency; zero/reserved take one cycle.
      slot_last  = (op_q == OP_LOAD || op_q == OP_STORE) ? SLOT_LAST_LONG : '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               walk_load  = 1'b1;
               op_d       = cmd_op_e'(cmd_op);
               stride_x_d = cmd_stride_x;
               stride_y_d = cmd_stride_y;
               slot_d     = '0;
               state_d    = ST_SLOT;
            end
         end
         ST_SLOT: begin
            if (slot_q == slot_last) begin
               slot_d = '0;
               if (walk_last) state_d  = ST_FINISH;
               else           walk_adv = 1'b1;
            end else begin
               slot_d = slot_q + 1'b1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Load fires at the end of its slot, store at the start; the rest of the slot is NOP.
      func_d = RISK_NOP;
      if (state_d == ST_SLOT) begin
         case (op_d)
            OP_LOAD:  func_d = (slot_d == SLOT_LAST_LONG) ? RISK_LOAD : RISK_NOP;
            OP_STORE: func_d = (slot_d == '0) ? RISK_STORE : RISK_NOP;
            OP_ZERO:  func_d = RISK_ZERO;
            default:  func_d = RISK_NOP;
         endcase
      end
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
      done_d  = (state_d == ST_FINISH);
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_LOAD;
         func_q     <= RISK_NOP;
         slot_q     <= '0;
         stride_x_q <= '0;
         stride_y_q <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         func_q     <= func_d;
         slot_q     <= slot_d;
         stride_x_q <= stride_x_d;
         stride_y_q <= stride_y_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign risk_func     = func_q;
   assign risk_stride_x = stride_x_q;
   assign risk_stride_y = stride_y_q;
   assign busy          = busy_q;
   assign cmd_ready     = ready_q;
   assign done          = done_q;

endmodule

// File: tb/tb_risk_tile_sequencer.sv
// Self-checking bench: directed literal cases plus randomized commands,
// all compared every cycle against a per-cycle expectation queue.
module tb_risk_tile_sequencer;

   localparam int MEM_LAT = 4;
   localparam int L_LONG  = MEM_LAT + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_reg_base;
   logic [14:0] cmd_base_addr;
   logic [13:0] cmd_stride_x, cmd_stride_y;
   logic [14:0] cmd_step_x, cmd_step_y;
   logic [3:0]  cmd_tiles_x, cmd_tiles_y;
   logic [2:0]  risk_func;
   logic [4:0]  risk_reg;
   logic [14:0] risk_addr;
   logic [13:0] risk_stride_x, risk_stride_y;
   logic        busy, done;

   int n_cmp = 0;
   int n_err = 0;

   risk_tile_sequencer #(.MEM_LAT(MEM_LAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_reg_base  (cmd_reg_base),
      .cmd_base_addr (cmd_base_addr),
      .cmd_stride_x  (cmd_stride_x),
      .cmd_stride_y  (cmd_stride_y),
      .cmd_step_x    (cmd_step_x),
      .cmd_step_y    (cmd_step_y),
      .cmd_tiles_x   (cmd_tiles_x),
      .cmd_tiles_y   (cmd_tiles_y),
      .risk_func     (risk_func),
      .risk_reg      (risk_reg),
      .risk_addr     (risk_addr),
      .risk_stride_x (risk_stride_x),
      .risk_stride_y (risk_stride_y),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [2:0]  func;
      logic [14:0] addr;
      logic [4:0]  rg;
      logic [13:0] sx;
      logic [13:0] sy;
      logic        busy;
      logic        done;
      logic        chk_dat;
      logic        chk_zero;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   cur_idle = 1'b0;
   bit   model_on = 1'b0;

   function automatic exp_t idle_entry(input bit after_reset);
      exp_t e;
      e          = '0;
      e.func     = 3'b111;
      e.chk_zero = after_reset;
      return e;
   endfunction

   // Expand a command into its cycle-by-cycle output expectations.
   task automatic expand_cmd();
      int   op, nx, ny, len;
      exp_t e;
      op  = int'(cmd_op);
      nx  = int'(cmd_tiles_x) + 1;
      ny  = int'(cmd_tiles_y) + 1;
      len = (op <= 1) ? L_LONG : 1;
      for (int ty = 0; ty < ny; ty++) begin
         for (int tx = 0; tx < nx; tx++) begin
            for (int c = 0; c < len; c++) begin
               e         = '0;
               e.addr    = 15'(int'(cmd_base_addr) + tx * int'(cmd_step_x) + ty * int'(cmd_step_y));
               e.rg      = 5'(int'(cmd_reg_base) + ty * nx + tx);
               e.sx      = cmd_stride_x;
               e.sy      = cmd_stride_y;
               e.busy    = 1'b1;
               e.chk_dat = 1'b1;
               case (op)
                  0:       e.func = (c == len - 1) ? 3'b000 : 3'b111;
                  1:       e.func = (c == 0) ? 3'b001 : 3'b111;
                  2:       e.func = 3'b010;
                  default: e.func = 3'b111;
               endcase
               exp_q.push_back(e);
            end
         end
      end
      e      = '0;
      e.func = 3'b111;
      e.busy = 1'b1;
      e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   // Advance the model by one cycle on each clock edge.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         cur      = idle_entry(1'b1);
         cur_idle = 1'b1;
         model_on = 1'b1;
      end else if (model_on) begin
         if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            cur_idle = 1'b0;
         end else if (cur_idle && cmd_valid) begin
            expand_cmd();
            cur      = exp_q.pop_front();
            cur_idle = 1'b0;
         end else begin
            cur      = idle_entry(1'b0);
            cur_idle = 1'b1;
         end
      end
   end

   // Compare DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      if (model_on) begin
         check("busy", 32'(busy), 32'(cur.busy));
         check("cmd_ready", 32'(cmd_ready), 32'(!cur.busy));
         check("done", 32'(done), 32'(cur.done));
         check("risk_func", 32'(risk_func), 32'(cur.func));
         if (cur.chk_dat) begin
            check("risk_addr", 32'(risk_addr), 32'(cur.addr));
            check("risk_reg", 32'(risk_reg), 32'(cur.rg));
            check("stride_x", 32'(risk_stride_x), 32'(cur.sx));
            check("stride_y", 32'(risk_stride_y), 32'(cur.sy));
         end
         if (cur.chk_zero) begin
            check("rst_addr", 32'(risk_addr), 32'h0);
            check("rst_reg", 32'(risk_reg), 32'h0);
            check("rst_sx", 32'(risk_stride_x), 32'h0);
            check("rst_sy", 32'(risk_stride_y), 32'h0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_cmd(input int op, input int rb, input int base, input int stx,
                          input int sty, input int tx, input int ty);
      cmd_op        = 2'(op);
      cmd_reg_base  = 5'(rb);
      cmd_base_addr = 15'(base);
      cmd_step_x    = 15'(stx);
      cmd_step_y    = 15'(sty);
      cmd_tiles_x   = 4'(tx);
      cmd_tiles_y   = 4'(ty);
      cmd_stride_x  = 14'($urandom);
      cmd_stride_y  = 14'($urandom);
   endtask

   // Raise cmd_valid and return just after the edge that accepts it.
   task automatic wait_accept();
      bit ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      for (int n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: cmd_ready never rose within 2000 cycles");
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      set_cmd(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle state literals.
      @(negedge clk);
      check("lit_idle_ready", 32'(cmd_ready), 32'h1);
      check("lit_idle_func", 32'(risk_func), 32'h7);

      // Zero, 2x2 tiles, reg_base 0.
      set_cmd(2, 0, 'h40, 1, 'h10, 1, 1);
      wait_accept();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("lit_zero_func", 32'(risk_func), 32'h2);
         check("lit_zero_reg", 32'(risk_reg), 32'(i));
      end
      @(negedge clk);
      check("lit_zero_done", 32'(done), 32'h1);

      // Load 1x1 at 0x100.
      set_cmd(0, 4, 'h100, 0, 0, 0, 0);
      wait_accept();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("lit_load_addr", 32'(risk_addr), 32'h100);
         check("lit_load_func", 32'(risk_func), (i == 4) ? 32'h0 : 32'h7);
      end
      @(negedge clk);
      check("lit_load_done", 32'(done), 32'h1);

      // Store 2x1, step_x 0x10, base 0x200.
      set_cmd(1, 0, 'h200, 'h10, 0, 1, 0);
      wait_accept();
      cmd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("lit_store_addr", 32'(risk_addr), (i < 5) ? 32'h200 : 32'h210);
         check("lit_store_func", 32'(risk_func), (i % 5 == 0) ? 32'h1 : 32'h7);
      end
      @(negedge clk);
      check("lit_store_done", 32'(done), 32'h1);

      // Address and reg wrap.
      set_cmd(2, 31, 'h7FF0, 'h20, 0, 1, 0);
      wait_accept();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("lit_wrap_addr0", 32'(risk_addr), 32'h7FF0);
      check("lit_wrap_reg0", 32'(risk_reg), 32'd31);
      @(negedge clk);
      check("lit_wrap_addr1", 32'(risk_addr), 32'h0010);
      check("lit_wrap_reg1", 32'(risk_reg), 32'd0);

      // Reset in the middle of the second tile of a 4-tile load.
      set_cmd(0, 2, 'h300, 'h8, 0, 3, 0);
      wait_accept();
      cmd_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("lit_rst_func", 32'(risk_func), 32'h7);
      check("lit_rst_busy", 32'(busy), 32'h0);
      check("lit_rst_ready", 32'(cmd_ready), 32'h1);
      check("lit_rst_done", 32'(done), 32'h0);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("lit_rst_quiet", 32'({busy, done}), 32'h0);
      end

      // Second command held on cmd_valid while the first runs.
      set_cmd(2, 3, 'h50, 0, 0, 0, 0);
      wait_accept();
      set_cmd(2, 7, 'h60, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_b2b_a_reg", 32'(risk_reg), 32'd3);
      @(negedge clk);
      check("lit_b2b_a_done", 32'(done), 32'h1);
      @(negedge clk);
      check("lit_b2b_idle", 32'({cmd_ready, busy}), 32'h2);
      @(negedge clk);
      check("lit_b2b_b_busy", 32'(busy), 32'h1);
      check("lit_b2b_b_reg", 32'(risk_reg), 32'd7);
      check("lit_b2b_b_func", 32'(risk_func), 32'h2);
      @(posedge clk);
      #1 cmd_valid = 1'b0;

      // Largest grid: 256 zero tiles, reg index wraps every 32.
      set_cmd(2, 5, 'h1234, 'h3, 'h101, 15, 15);
      wait_accept();
      cmd_valid = 1'b0;

      // Random traffic, including valid during busy and occasional resets.
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #1;
         reset     = ($urandom_range(0, 599) == 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         set_cmd(int'($urandom_range(0, 3)), int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      repeat (200) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
